// File: rtl/periph_fifo_ot.sv
// Request FIFO with an outstanding-transaction limiter between an upstream and a downstream
// port, plus an optional one-cycle response register and an unexpected-response flag.
module periph_fifo_ot #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned REQ_DEPTH  = 2,
    parameter int unsigned MAX_OT     = 4,
    parameter int unsigned RSP_REG    = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               test_en_i,
    input  logic                               data_req_i,
    input  logic [ADDR_WIDTH-1:0]              data_add_i,
    input  logic                               data_wen_i,
    input  logic [DATA_WIDTH-1:0]              data_wdata_i,
    input  logic [BE_WIDTH-1:0]                data_be_i,
    output logic                               data_gnt_o,
    output logic                               data_req_o,
    output logic [ADDR_WIDTH-1:0]              data_add_o,
    output logic                               data_wen_o,
    output logic [DATA_WIDTH-1:0]              data_wdata_o,
    output logic [BE_WIDTH-1:0]                data_be_o,
    input  logic                               data_gnt_i,
    input  logic                               data_r_valid_i,
    input  logic                               data_r_opc_i,
    input  logic [DATA_WIDTH-1:0]              data_r_rdata_i,
    output logic                               data_r_valid_o,
    output logic                               data_r_opc_o,
    output logic [DATA_WIDTH-1:0]              data_r_rdata_o,
    output logic [$clog2(REQ_DEPTH+1)-1:0]     fifo_cnt_o,
    output logic [$clog2(MAX_OT+1)-1:0]        ot_cnt_o,
    output logic                               idle_o,
    output logic                               err_rsp_o
);

    localparam int unsigned CntW = $clog2(REQ_DEPTH + 1);
    localparam int unsigned OtW  = $clog2(MAX_OT + 1);
    localparam int unsigned PtrW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int unsigned EntW = ADDR_WIDTH + 1 + DATA_WIDTH + BE_WIDTH;

    logic [EntW-1:0] mem_q [REQ_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [OtW-1:0]  ot_q, ot_d;
    logic            push, pop, rsp_err;
    logic            unused_test_en;

    assign unused_test_en = test_en_i;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(REQ_DEPTH - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // Grant depends on state only, so a same-cycle pop never frees room for a push.
    assign data_gnt_o = (cnt_q < CntW'(REQ_DEPTH));
    assign push       = data_req_i && data_gnt_o;
    assign data_req_o = (cnt_q != '0) && (ot_q < OtW'(MAX_OT));
    assign pop        = data_req_o && data_gnt_i;

    assign {data_add_o, data_wen_o, data_wdata_o, data_be_o} = mem_q[rd_ptr_q];

    // A response with nothing outstanding (and no pop to cover it) is flagged, not counted.
    assign rsp_err = data_r_valid_i && !pop && (ot_q == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ot_d     = ot_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
        if (pop && !data_r_valid_i) begin
            ot_d = ot_q + OtW'(1);
        end else if (!pop && data_r_valid_i && (ot_q != '0)) begin
            ot_d = ot_q - OtW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ot_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ot_q     <= ot_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {data_add_i, data_wen_i, data_wdata_i, data_be_i};
        end
    end

    generate
        if (RSP_REG != 0) begin : g_rsp_reg
            logic                  valid_q, opc_q, err_q;
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                    opc_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end else begin
                    valid_q <= data_r_valid_i;
                    err_q   <= rsp_err;
                    if (data_r_valid_i) begin
                        opc_q   <= data_r_opc_i;
                        rdata_q <= data_r_rdata_i;
                    end
                end
            end

            assign data_r_valid_o = valid_q;
            assign data_r_opc_o   = opc_q;
            assign data_r_rdata_o = rdata_q;
            assign err_rsp_o      = err_q;
        end else begin : g_rsp_comb
            assign data_r_valid_o = data_r_valid_i;
            assign data_r_opc_o   = data_r_opc_i;
            assign data_r_rdata_o = data_r_rdata_i;
            assign err_rsp_o      = rsp_err;
        end
    endgenerate

    assign fifo_cnt_o = cnt_q;
    assign ot_cnt_o   = ot_q;
    assign idle_o     = (cnt_q == '0) && (ot_q == '0) && !data_r_valid_o;

endmodule

// File: doc/periph_fifo_ot.md
PERIPH_FIFO_OT -- requirements
Module: periph_fifo_ot

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, write/read data width.
REQ-003 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-004 SHALL have parameter REQ_DEPTH, default 2, request FIFO entries (>=1, power of two not required).
REQ-005 SHALL have parameter MAX_OT, default 4, maximum outstanding downstream transactions (>=1).
REQ-006 SHALL have parameter RSP_REG, default 1, 1 = registered response path, 0 = combinational.
REQ-007 SHALL have ports: clk_i in 1, clock; rst_ni in 1, reset, asynchronous, active-low; test_en_i in 1, test mode (no functional effect).
REQ-008 SHALL have upstream request ports: data_req_i in 1; data_add_i in ADDR_WIDTH; data_wen_i in 1; data_wdata_i in DATA_WIDTH; data_be_i in BE_WIDTH; data_gnt_o out 1.
REQ-009 SHALL have downstream request ports: data_req_o out 1; data_add_o out ADDR_WIDTH; data_wen_o out 1; data_wdata_o out DATA_WIDTH; data_be_o out BE_WIDTH; data_gnt_i in 1.
REQ-010 SHALL have response ports: data_r_valid_i in 1, data_r_opc_i in 1, data_r_rdata_i in DATA_WIDTH; data_r_valid_o out 1, data_r_opc_o out 1, data_r_rdata_o out DATA_WIDTH.
REQ-011 SHALL have status ports: fifo_cnt_o out clog2(REQ_DEPTH+1), entries held; ot_cnt_o out clog2(MAX_OT+1), outstanding count; idle_o out 1; err_rsp_o out 1, unexpected-response pulse.

Function
REQ-012 Request FIFO SHALL store {add, wen, wdata, be} in arrival order; push = data_req_i && data_gnt_o.
REQ-013 data_gnt_o SHALL equal (fifo_cnt < REQ_DEPTH), combinational from state only; no push when full even if a pop occurs same cycle.
REQ-014 Pushed entry SHALL be visible at downstream outputs no earlier than the next cycle (no combinational bypass); minimum request latency 1 cycle.
REQ-015 data_req_o SHALL equal (fifo_cnt != 0) && (ot_cnt < MAX_OT); data_add_o/wen/wdata/be SHALL show the head entry whenever fifo_cnt != 0.
REQ-016 Pop SHALL occur on data_req_o && data_gnt_i; head payload SHALL stay stable while data_req_o high and data_gnt_i low.
REQ-017 Simultaneous push and pop with 0 < fifo_cnt < REQ_DEPTH SHALL leave fifo_cnt unchanged; pointers SHALL wrap from REQ_DEPTH-1 to 0.
REQ-018 ot_cnt SHALL increment on pop, decrement on data_r_valid_i, stay unchanged when both occur in the same cycle.
REQ-019 data_r_valid_i with ot_cnt==0 and no pop that cycle SHALL pulse err_rsp_o for one cycle (RSP_REG=1: aligned with data_r_valid_o); ot_cnt SHALL stay 0 (no underflow).
REQ-020 ot_cnt SHALL never exceed MAX_OT; at MAX_OT data_req_o SHALL be 0 until a response arrives, then re-assert the cycle after the decrement.
REQ-021 RSP_REG=1: data_r_valid_o/opc_o/rdata_o SHALL be data_r_*_i delayed exactly one cycle; rdata/opc SHALL load only when data_r_valid_i=1.
REQ-022 RSP_REG=0: data_r_*_o SHALL equal data_r_*_i combinationally.
REQ-023 Responses SHALL be forwarded unconditionally (no backpressure on response path).
REQ-024 idle_o SHALL equal (fifo_cnt==0) && (ot_cnt==0) && !data_r_valid_o.

Reset
REQ-025 On rst_ni low, asynchronously: FIFO pointers and fifo_cnt = 0, ot_cnt = 0, data_req_o = 0, data_r_valid_o = 0, data_r_opc_o = 0, data_r_rdata_o = 0, err_rsp_o = 0, data_gnt_o = 1, idle_o = 1.
REQ-026 Reset mid-operation SHALL discard buffered requests and outstanding count; responses arriving after reset release with ot_cnt==0 SHALL raise err_rsp_o.

Verification
REQ-027 Default params, data_gnt_i=1, one write add=0x100 at cycle 0 -> data_req_o=1 with add=0x100 at cycle 1, ot_cnt_o=1 at cycle 2.
REQ-028 data_gnt_i=0, 3 back-to-back requests (REQ_DEPTH=2) -> first two granted, third sees data_gnt_o=0, fifo_cnt_o=2; release gnt -> order preserved A,B.
REQ-029 MAX_OT=4, data_gnt_i=1, no responses, 6 requests -> exactly 4 pops, data_req_o=0, ot_cnt_o=4; one data_r_valid_i -> ot_cnt_o=3 then next pop.
REQ-030 Same-cycle pop and data_r_valid_i at ot_cnt=2 -> ot_cnt stays 2; RSP_REG=1 rdata 0xDEADBEEF in -> out one cycle later, idle_o low that cycle.
REQ-031 data_r_valid_i with ot_cnt=0 -> err_rsp_o single pulse, ot_cnt_o remains 0.
REQ-032 Assert rst_ni low with fifo_cnt=2, ot_cnt=3 -> all outputs reach REQ-025 values immediately, without a clock edge.
